bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_pkg.sv | 31 +++
 rtl/bus_arbiter_if.sv | 29 ++
 rtl/bus_arbiter_next_owner.sv | 43 ++++
 rtl/bus_arbiter.sv | 45 ++++
 tb/tb_bus_arbiter.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared constants, owner type and grant decode for bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    localparam int unsigned NUM_MASTERS = 4;

    typedef logic [1:0] owner_t;

    localparam owner_t BUS_MASTER_0 = 2'd0;
    localparam owner_t BUS_MASTER_1 = 2'd1;
    localparam owner_t BUS_MASTER_2 = 2'd2;
    localparam owner_t BUS_MASTER_3 = 2'd3;

    // Active-low bus levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // One-cold grant vector: only bit[owner] is low
    function automatic logic [NUM_MASTERS-1:0] grant_decode(input owner_t owner);
        logic [NUM_MASTERS-1:0] grant_n;
        grant_n = {NUM_MASTERS{DISABLE_}};
        grant_n[owner] = ENABLE_;
        return grant_n;
    endfunction

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Active-low request/grant bundle between bus masters and arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if;

    logic in0;
    logic in1;
    logic in2;
    logic in3;
    logic out0;
    logic out1;
    logic out2;
    logic out3;

    modport master (
        output in0, in1, in2, in3,
        input  out0, out1, out2, out3
    );

    modport slave (
        input  in0, in1, in2, in3,
        output out0, out1, out2, out3
    );

endinterface : bus_arbiter_if
`default_nettype wire

// File: rtl/bus_arbiter_next_owner.sv
`default_nettype none
// ============================================================================
// Module      : arb_next_owner
// Description : Combinational next-owner selection from current owner and
//               active-low requests. Macro ARB_FIXED_PRIO_EN selects a
//               fixed-priority search (master 0 highest) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_next_owner
    import bus_arbiter_pkg::*;
(
    input  owner_t                 owner_i,
    input  logic [NUM_MASTERS-1:0] req_n_i,
    output owner_t                 owner_o
);

    owner_t cand;

    always_comb begin
        owner_o = owner_i;
        cand    = owner_i;
        if (req_n_i[owner_i] == DISABLE_) begin
`ifdef ARB_FIXED_PRIO_EN
            // Descending scan so the lowest requesting index wins
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (req_n_i[i] == ENABLE_) begin
                    owner_o = owner_t'(i);
                end
            end
`else
            // Scan owner+3 down to owner+1 so the nearest successor wins
            for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
                cand = owner_i + owner_t'(k);
                if (req_n_i[cand] == ENABLE_) begin
                    owner_o = cand;
                end
            end
`endif
        end
    end

endmodule : arb_next_owner
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Four-master arbiter with registered owner and one-cold grants.
//               Optional macro: ARB_FIXED_PRIO_EN (fixed-priority release search).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    owner_t                 owner_q;
    owner_t                 owner_d;
    logic [NUM_MASTERS-1:0] req_n;
    logic [NUM_MASTERS-1:0] grant_n;

    assign req_n = {bus.in3, bus.in2, bus.in1, bus.in0};

    arb_next_owner u_next_owner (
        .owner_i (owner_q),
        .req_n_i (req_n),
        .owner_o (owner_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= BUS_MASTER_0;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Grants come straight off the owner flop: no path from requests
    assign grant_n  = grant_decode(owner_q);
    assign bus.out0 = grant_n[0];
    assign bus.out1 = grant_n[1];
    assign bus.out2 = grant_n[2];
    assign bus.out3 = grant_n[3];

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Scoreboard bench for bus_arbiter (directed request vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [3:0] grant_n;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    bus_arbiter_if bus ();

    bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] grant_of(input int owner);
        logic [3:0] g;
        g = 4'b1111;
        g[owner] = 1'b0;
        return g;
    endfunction

    function automatic logic [3:0] out_vec();
        return {bus.out3, bus.out2, bus.out1, bus.out0};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got out3..0=%b expected %b", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] req_n);
        {bus.in3, bus.in2, bus.in1, bus.in0} = req_n;
    endtask

    // Drive requests for the next edge and queue the owner expected after it
    task automatic step(input logic [3:0] req_n, input int exp_owner, input string name);
        exp_t e;
        @(negedge clk);
        set_in(req_n);
        e.grant_n = grant_of(exp_owner);
        e.name    = name;
        sb_q.push_back(e);
    endtask

    // Monitor: compare after every rising edge while expectations are queued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, out_vec(), e.grant_n);
                checks++;
                if ($countones(~out_vec()) != 1) begin
                    errors++;
                    $display("FAIL onehot_%s: got out3..0=%b expected exactly one low", e.name, out_vec());
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   fp_owner;
        reset = 1'b0;
        set_in(4'b1111);
        #3;
        check("reset_async", out_vec(), grant_of(0));

        @(negedge clk);
        reset = 1'b1;

        step(4'b1111, 0, "park0");
        step(4'b1111, 0, "park1");
        step(4'b1111, 0, "park2");

        step(4'b0110, 0, "hold0");
        step(4'b0110, 0, "hold1");
        step(4'b0110, 0, "hold2");

        step(4'b0111, 3, "handover_0to3");
        step(4'b0111, 3, "hold3");

        step(4'b1010, 0, "wrap_3to0");
        step(4'b0101, 1, "rr_0to1");
        step(4'b1011, 2, "rr_1to2");

`ifdef ARB_FIXED_PRIO_EN
        fp_owner = 1;
`else
        fp_owner = 3;
`endif
        step(4'b0101, fp_owner, "release_from2");
        step(4'b1011, 2, "to_owner2");
        step(4'b1011, 2, "hold_owner2");

        // Reset pulse between edges while master 2 owns the bus
        @(posedge clk);
        #3;
        reset = 1'b0;
        set_in(4'b1010);
        #1;
        check("reset_mid_async", out_vec(), grant_of(0));
        #2;
        reset = 1'b1;
        e.grant_n = grant_of(0);
        e.name    = "post_reset_hold";
        sb_q.push_back(e);

        step(4'b1010, 0, "post_reset_hold1");
        step(4'b1010, 0, "post_reset_hold2");
        step(4'b1011, 2, "post_reset_rel");
        step(4'b1111, 2, "park_owner2");

        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire
